emp_core: RTL and testbench

- Two-phase initiator that drives the shared instruction/data memory.
- Each instruction takes one memory fetch phase (E=0) followed by one execute phase (E=1).
- The core decodes the fetched word, then drives the memory's nextPC, addr_in, data_in and S. It owns a 16x32 register file and retires one instruction per fetch+execute pair.

---
 rtl/emp_core_if.sv | 30 +++
 rtl/emp_core.sv | 179 +++++++++++++++++
 tb/tb_emp_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emp_core_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : emp_core_if
// Description : Bus between the emp_core initiator and the shared
//               instruction/data memory. The memory provides phase, PC and read
//               data. The core returns next PC, data address, store data and
//               store enable.
// Revision    : 1.0  initial release
// ============================================================================
interface emp_core_if;
    logic        E;        // memory phase: 0 = fetch, 1 = execute
    logic [31:0] PCout;    // current PC held by memory
    logic [31:0] Mout;     // instruction (E=0) or data word at addr_in (E=1)
    logic [31:0] nextPC;   // next PC, sampled by memory on E rise
    logic [31:0] addr_in;  // data byte address
    logic [31:0] data_in;  // store data
    logic        S;        // store enable, honoured in execute phase only

    modport master (
        input  E, PCout, Mout,
        output nextPC, addr_in, data_in, S
    );

    modport slave (
        output E, PCout, Mout,
        input  nextPC, addr_in, data_in, S
    );
endinterface
`default_nettype wire

// File: rtl/emp_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : emp_core
// Description : Two-phase initiator for a shared instruction/data memory.
//               The memory fetches while E=0 and executes while E=1. The core
//               decodes the current instruction and drives next PC, the data
//               address, the store data and the store enable. Writeback into
//               the 16x32 register file retires the instruction at the end of
//               the execute phase.
// Revision    : 1.0  initial release
// ============================================================================
module emp_core #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NREG     = 16
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    emp_core_if.master  bus,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired,
    input  logic [3:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_ADDI = 4'd3;
    localparam logic [3:0] c_OP_LW   = 4'd4;
    localparam logic [3:0] c_OP_SW   = 4'd5;
    localparam logic [3:0] c_OP_BEQ  = 4'd6;
    localparam logic [3:0] c_OP_J    = 4'd7;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [31:0] r_ir;          // instruction captured during fetch
    logic        r_prev_e;      // E as sampled on the previous edge
    logic        r_halted;
    logic        r_illegal;
    logic [31:0] r_retired;
    logic [31:0] r_regs [NREG];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0] w_inst;
    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs;
    logic [3:0]  w_rt;
    logic [15:0] w_imm;
    logic [31:0] w_simm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_eff_addr;
    logic        w_is_illegal;
    logic        w_exec;
    logic        w_wr_en;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_seq;
    logic [31:0] w_next_pc;

    // While fetching, the instruction is still on the memory read port.
    // During execute, the read port carries data, so the held copy is used.
    assign w_inst = bus.E ? r_ir : bus.Mout;

    assign w_op   = w_inst[31:28];
    assign w_rd   = w_inst[27:24];
    assign w_rs   = w_inst[23:20];
    assign w_rt   = w_inst[19:16];
    assign w_imm  = w_inst[15:0];
    assign w_simm = {{16{w_imm[15]}}, w_imm};

    // r0 is hardwired to zero on every read port
    assign w_rs_val = (w_rs == 4'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 4'd0) ? 32'd0 : r_regs[w_rt];
    assign dbg_data = (dbg_sel == 4'd0) ? 32'd0 : r_regs[dbg_sel];

    assign w_eff_addr   = w_rs_val + w_simm;
    assign w_is_illegal = w_op[3] && (w_op != c_OP_HALT);

    // Writeback fires only on an execute edge that directly follows a fetch
    // edge. This way, a memory that stalls in one phase never causes a
    // double retire.
    assign w_exec = bus.E && !r_prev_e && !r_halted;

    // Select the register-file write value for the decoded instruction
    always_comb begin
        w_wr_en   = 1'b0;
        w_wb_data = w_rs_val + w_rt_val;
        case (w_op)
            c_OP_ADD: begin
                w_wr_en   = 1'b1;
                w_wb_data = w_rs_val + w_rt_val;
            end
            c_OP_SUB: begin
                w_wr_en   = 1'b1;
                w_wb_data = w_rs_val - w_rt_val;
            end
            c_OP_ADDI: begin
                w_wr_en   = 1'b1;
                w_wb_data = w_eff_addr;
            end
            c_OP_LW: begin
                w_wr_en   = 1'b1;
                w_wb_data = bus.Mout;
            end
            default: begin
                w_wr_en   = 1'b0;
                w_wb_data = w_rs_val + w_rt_val;
            end
        endcase
    end

    // Next-PC selection. HALT and the halted state both hold the PC in place.
    always_comb begin
        w_pc_seq  = bus.PCout + 32'd4;
        w_next_pc = w_pc_seq;
        if (r_halted || (w_op == c_OP_HALT)) begin
            w_next_pc = bus.PCout;
        end else if ((w_op == c_OP_BEQ) && (w_rs_val == w_rt_val)) begin
            w_next_pc = w_pc_seq + {w_simm[29:0], 2'b00};
        end else if (w_op == c_OP_J) begin
            w_next_pc = {14'd0, w_imm, 2'b00};
        end
    end

    assign bus.nextPC  = {w_next_pc[31:2], 2'b00};
    assign bus.addr_in = w_eff_addr;
    assign bus.data_in = w_rt_val;
    assign bus.S       = (w_op == c_OP_SW) && !r_halted;

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

    // Phase tracking, IR capture and retire/status bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir      <= 32'd0;
            r_prev_e  <= 1'b1;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= 32'd0;
        end else begin
            assert (RESET_PC[1:0] == 2'b00);
            r_prev_e <= bus.E;
            if (!bus.E) begin
                r_ir <= bus.Mout;
            end
            if (w_exec) begin
                r_retired <= r_retired + 32'd1;
                if (w_op == c_OP_HALT) begin
                    r_halted <= 1'b1;
                end
                if (w_is_illegal) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // Register file write port, with r0 writes discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_exec && w_wr_en && (w_rd != 4'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emp_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_emp_core
// Description : Self-checking bench for emp_core. It contains a two-phase
//               memory and an instruction-level reference model. The model is
//               checked against the core on every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_emp_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  dbg_sel = 4'd0;
    logic [31:0] dbg_data;
    logic [31:0] retired;
    logic        halted;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    emp_core_if bif();

    emp_core #(.RESET_PC(32'h0), .NREG(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.master),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic        env_e;
    logic [31:0] env_pc;
    logic [31:0] env_daddr;
    logic [31:0] env_mem [256];
    logic        ld_en = 1'b0;
    logic        ld_clr = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'd0;

    // Memory is reset from ~rst. It latches the data address on E rise,
    // when the core's address is already stable.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_e     <= 1'b0;
            env_pc    <= 32'h0;
            env_daddr <= 32'h0;
            if (ld_clr) begin
                for (int i = 0; i < 256; i++) env_mem[i] <= 32'd0;
            end else if (ld_en) begin
                env_mem[ld_addr] <= ld_data;
            end
        end else if (!env_e) begin
            env_pc    <= bif.nextPC;
            env_daddr <= bif.addr_in;
            env_e     <= 1'b1;
        end else begin
            if (bif.S) env_mem[bif.addr_in[9:2]] <= bif.data_in;
            env_e <= 1'b0;
        end
    end

    assign bif.E     = env_e;
    assign bif.PCout = env_pc;
    assign bif.Mout  = env_e ? env_mem[env_daddr[9:2]] : env_mem[env_pc[9:2]];

    // ---------------- reference model (one instruction at a time) ----------------
    logic [31:0] m_regs [16];
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_illegal;
    logic [31:0] m_retired;
    logic [31:0] mmem [256];
    logic [31:0] prog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int imm);
        return {op[3:0], rd[3:0], rs[3:0], rt[3:0], imm[15:0]};
    endfunction

    task automatic p(input int op, input int rd, input int rs, input int rt, input int imm);
        prog.push_back(enc(op, rd, rs, rt, imm));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_pc      = 32'h0;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        m_retired = 32'd0;
    endtask

    // What the bus must show for the instruction at the model PC
    task automatic m_expect(output logic [31:0] npc, output logic [31:0] addr,
                            output logic [31:0] data, output logic s);
        logic [31:0] inst;
        int          op;
        int          simm;
        inst = mmem[m_pc[9:2]];
        op   = int'(inst[31:28]);
        simm = int'($signed(inst[15:0]));
        addr = m_regs[inst[23:20]] + 32'(simm);
        data = m_regs[inst[19:16]];
        s    = (op == 5) && !m_halted;
        if (m_halted || op == 15)
            npc = m_pc;
        else if (op == 6 && m_regs[inst[23:20]] == m_regs[inst[19:16]])
            npc = m_pc + 32'd4 + 32'(simm * 4);
        else if (op == 7)
            npc = 32'(inst[15:0]) * 32'd4;
        else
            npc = m_pc + 32'd4;
        npc = npc & 32'hFFFF_FFFC;
    endtask

    task automatic model_step();
        logic [31:0] inst, npc, addr, data;
        logic        s;
        int          op;
        int          rd;
        if (m_halted) return;
        inst = mmem[m_pc[9:2]];
        op   = int'(inst[31:28]);
        rd   = int'(inst[27:24]);
        m_expect(npc, addr, data, s);
        m_retired = m_retired + 32'd1;
        case (op)
            1: if (rd != 0) m_regs[rd] = m_regs[inst[23:20]] + m_regs[inst[19:16]];
            2: if (rd != 0) m_regs[rd] = m_regs[inst[23:20]] - m_regs[inst[19:16]];
            3: if (rd != 0) m_regs[rd] = addr;
            4: if (rd != 0) m_regs[rd] = mmem[addr[9:2]];
            5: mmem[addr[9:2]] = data;
            15: m_halted = 1'b1;
            default: if (op >= 8) m_illegal = 1'b1;
        endcase
        m_pc = npc;
    endtask

    // ---------------- every-cycle comparison ----------------
    logic [31:0] c_npc, c_addr, c_data;
    logic        c_s, c_e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_retired", retired, 32'd0);
            chk("reset_halted", {31'd0, halted}, 32'd0);
            chk("reset_illegal", {31'd0, illegal}, 32'd0);
        end else begin
            c_e = bif.E;
            m_expect(c_npc, c_addr, c_data, c_s);
            if (!c_e) begin
                chk("PCout", bif.PCout, m_pc);
                chk("nextPC", bif.nextPC, c_npc);
            end
            chk("addr_in", bif.addr_in, c_addr);
            chk("data_in", bif.data_in, c_data);
            chk("S", {31'd0, bif.S}, {31'd0, c_s});
            chk("retired", retired, m_retired);
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
            for (int i = 0; i < 16; i++) begin
                dbg_sel = i[3:0];
                #0.1;
                chk("regfile", dbg_data, m_regs[i]);
            end
            if (c_e) model_step();
        end
    end

    // Store activity seen in execute phases
    int          s_cnt = 0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_data = 32'd0;
    always @(negedge clk) begin
        if (rst && bif.E && bif.S) begin
            s_cnt++;
            s_addr = bif.addr_in;
            s_data = bif.data_in;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_prog();
        @(negedge clk); ld_clr = 1'b1;
        @(negedge clk); ld_clr = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) begin
            ld_en   = 1'b1;
            ld_addr = i[7:0];
            ld_data = prog[i];
            mmem[i] = prog[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    task automatic start_prog();
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        load_prog();
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        @(posedge clk); #2;
        dbg_sel = r[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic wait_halt(input int max_cyc);
        int c = 0;
        while (!halted && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (!halted) begin
            n_checks++;
            n_fail++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles", halted, c);
        end
    endtask

    task automatic wait_pc(input logic [31:0] pc, input int max_cyc);
        int c = 0;
        @(negedge clk);
        while (!(bif.E == 1'b0 && bif.PCout == pc) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (c >= max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL pc_timeout: PCout=%h required %h", bif.PCout, pc);
        end
    endtask

    // ---------------- directed and random programs ----------------
    logic [31:0] v;
    initial begin
        model_reset();

        // ADDI chain followed by HALT
        prog.delete();
        p(3, 1, 0, 0, 5); p(3, 2, 1, 0, -7); p(15, 0, 0, 0, 0);
        start_prog();
        wait_halt(40);
        read_reg(1, v); chk("p1_r1", v, 32'd5);
        read_reg(2, v); chk("p1_r2", v, 32'hFFFF_FFFE);
        chk("p1_retired", retired, 32'd3);
        chk("p1_pc", bif.PCout, 32'h8);

        // Store and load through the same address
        prog.delete();
        p(3, 1, 0, 0, 16'h40); p(3, 2, 0, 0, 16'h1234); p(5, 0, 1, 2, 4); p(4, 3, 1, 0, 4); p(15, 0, 0, 0, 0);
        start_prog();
        s_cnt = 0;
        wait_halt(60);
        chk("p2_store_count", 32'(s_cnt), 32'd1);
        chk("p2_store_addr", s_addr, 32'h44);
        chk("p2_store_data", s_data, 32'h1234);
        read_reg(3, v); chk("p2_r3", v, 32'h1234);

        // BEQ not taken at 0x10
        prog.delete();
        p(3, 1, 0, 0, 1); p(3, 2, 0, 0, 2); p(0, 0, 0, 0, 0); p(0, 0, 0, 0, 0);
        p(6, 0, 1, 2, 5); p(15, 0, 0, 0, 0);
        start_prog();
        wait_pc(32'h10, 40);
        chk("beq_not_taken", bif.nextPC, 32'h14);
        wait_halt(40);

        // Taken BEQ at 0x10, then J to 0xC
        prog.delete();
        p(7, 0, 0, 0, 4); p(0, 0, 0, 0, 0); p(0, 0, 0, 0, 0); p(15, 0, 0, 0, 0);
        p(6, 0, 0, 0, 2); p(0, 0, 0, 0, 0); p(0, 0, 0, 0, 0); p(7, 0, 0, 0, 3);
        start_prog();
        wait_pc(32'h10, 40);
        chk("beq_taken", bif.nextPC, 32'h1C);
        wait_pc(32'h1C, 40);
        chk("jump", bif.nextPC, 32'hC);
        wait_halt(40);
        chk("jump_halt_pc", bif.PCout, 32'hC);

        // r0 writes are discarded, and opcode 9 sets the illegal flag
        prog.delete();
        p(3, 0, 0, 0, 9); p(9, 1, 0, 0, 3); p(15, 0, 0, 0, 0);
        start_prog();
        wait_halt(40);
        read_reg(0, v); chk("r0_zero", v, 32'd0);
        read_reg(1, v); chk("illegal_no_write", v, 32'd0);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        chk("illegal_retired", retired, 32'd3);

        // Reset during the execute phase of ADDI r4
        prog.delete();
        p(3, 4, 0, 0, 7); p(15, 0, 0, 0, 0);
        start_prog();
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        read_reg(4, v); chk("reset_r4", v, 32'd0);
        chk("reset_mid_retired", retired, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("restart_pc", bif.PCout, 32'h0);
        wait_halt(40);
        read_reg(4, v); chk("restart_r4", v, 32'd7);

        // Frozen after HALT
        repeat (20) @(negedge clk);
        chk("frozen_retired", retired, 32'd2);
        chk("frozen_pc", bif.PCout, 32'h4);

        // Random programs, checked cycle by cycle against the model
        for (int round = 0; round < 4; round++) begin
            prog.delete();
            for (int i = 0; i < 48; i++) begin
                int sel, op, imm;
                sel = int'($urandom_range(0, 31));
                if (sel == 31)      op = 15;
                else if (sel >= 28) op = 8 + (sel - 28);
                else                op = sel % 8;
                if (op == 7)      imm = int'($urandom_range(0, 47));
                else if (op == 6) imm = int'($urandom_range(0, 15)) - 8;
                else              imm = int'($urandom_range(0, 65535));
                p(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), imm);
            end
            start_prog();
            repeat (250) @(negedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
